// File: rtl/argmax_seq.sv
// Sequencer that fetches LEN words from memory and reports the maximum element and its index.
// Define ARGMAX_SIGNED_EN to compare elements as two's-complement signed instead of unsigned.
module argmax_seq #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [31:0]       base_addr_i,
  input  logic [IDX_W-1:0]  len_i,
  output logic [31:0]       mem_addr_o,
  output logic              mem_rd_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] max_val_o,
  output logic [31:0]       max_idx_o
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    CMP,
    FIN
  } state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    len_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   elem_q;
  logic [DATA_W-1:0]   max_val_q;
  logic [IDX_W-1:0]    max_idx_q;
  logic [31:0]         mem_addr_q;
  logic                mem_rd_q;
  logic                busy_q;
  logic                done_q;
  logic                take_d;
  logic                last_d;

  // The first element always seeds the maximum; later ones must be strictly greater so ties keep the earlier index.
  always_comb begin
    take_d = 1'b0;
`ifdef ARGMAX_SIGNED_EN
    take_d = (idx_q == '0) || ($signed(elem_q) > $signed(max_val_q));
`else
    take_d = (idx_q == '0) || (elem_q > max_val_q);
`endif
    last_d = (idx_q == (len_q - IDX_W'(1)));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      elem_q     <= '0;
      max_val_q  <= '0;
      max_idx_q  <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            len_q     <= len_i;
            idx_q     <= '0;
            max_val_q <= '0;
            max_idx_q <= '0;
            busy_q    <= 1'b1;
            if (len_i != '0) begin
              state_q    <= FETCH;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= base_addr_i;
            end else begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (mem_ack_i) begin
            elem_q   <= mem_data_i;
            mem_rd_q <= 1'b0;
            state_q  <= CMP;
          end
        end
        CMP: begin
          if (take_d) begin
            max_val_q <= elem_q;
            max_idx_q <= idx_q;
          end
          if (last_d) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end else begin
            // Address advances by one word alongside the index, wrapping modulo 2^32.
            idx_q      <= idx_q + IDX_W'(1);
            mem_addr_q <= mem_addr_q + 32'd4;
            mem_rd_q   <= 1'b1;
            state_q    <= FETCH;
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr_o = mem_addr_q;
  assign mem_rd_o   = mem_rd_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign max_val_o  = max_val_q;
  assign max_idx_o  = {{(32-IDX_W){1'b0}}, max_idx_q};

endmodule

// File: tb/tb_argmax_seq.sv
// Self-checking bench for argmax_seq: drives memory handshakes and compares against a vector-level argmax model.
module tb_argmax_seq;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [31:0] base_addr_i;
  logic [7:0]  len_i;
  logic [31:0] mem_addr_o;
  logic        mem_rd_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] max_val_o;
  logic [31:0] max_idx_o;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] memWords [256];

  always #5 clk_i = ~clk_i;

  argmax_seq dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .base_addr_i(base_addr_i),
    .len_i(len_i), .mem_addr_o(mem_addr_o), .mem_rd_o(mem_rd_o), .mem_ack_i(mem_ack_i),
    .mem_data_i(mem_data_i), .busy_o(busy_o), .done_o(done_o), .max_val_o(max_val_o),
    .max_idx_o(max_idx_o)
  );

  function automatic bit isGreater(input logic [31:0] a, input logic [31:0] b);
`ifdef ARGMAX_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  // Reference: find the largest value over the vector, then the first position holding it.
  function automatic void refArgmax(input int len, output logic [31:0] mv, output logic [31:0] mi);
    mv = 32'd0;
    mi = 32'd0;
    if (len > 0) begin
      mv = memWords[0];
      for (int i = 1; i < len; i++) if (isGreater(memWords[i], mv)) mv = memWords[i];
      for (int i = len - 1; i >= 0; i--) if (memWords[i] == mv) mi = 32'(i);
    end
  endfunction

  task automatic runOp(input logic [31:0] base, input int len, input int waitCycles,
                       input bit pokeStart, input string name);
    int expDone;
    int fetchIdx;
    int waitCnt;
    bit sawRd;
    logic [31:0] expV;
    logic [31:0] expI;
    refArgmax(len, expV, expI);
    expDone  = 2 * len + 1 + len * waitCycles;
    fetchIdx = 0;
    waitCnt  = 0;
    sawRd    = 1'b0;
    @(negedge clk_i);
    start_i     = 1'b1;
    base_addr_i = base;
    len_i       = len[7:0];
    mem_ack_i   = 1'b0;
    for (int c = 1; c <= expDone + 1; c++) begin
      @(negedge clk_i);
      start_i = pokeStart && (c == 3);
      if (pokeStart && c == 3) begin
        base_addr_i = 32'hDEAD0000;
        len_i       = 8'd1;
      end
      vectors++;
      if (busy_o !== (c <= expDone)) begin
        miscompares++;
        $display("[TB] FAIL %s busy cycle %0d: got %b want %b", name, c, busy_o, (c <= expDone));
      end
      vectors++;
      if (done_o !== (c == expDone)) begin
        miscompares++;
        $display("[TB] FAIL %s done cycle %0d: got %b want %b", name, c, done_o, (c == expDone));
      end
      if (c == expDone) begin
        vectors++;
        if (max_val_o !== expV) begin
          miscompares++;
          $display("[TB] FAIL %s max_val: got %h want %h", name, max_val_o, expV);
        end
        vectors++;
        if (max_idx_o !== expI) begin
          miscompares++;
          $display("[TB] FAIL %s max_idx: got %0d want %0d", name, max_idx_o, expI);
        end
      end
      if (mem_rd_o === 1'b1) begin
        sawRd = 1'b1;
        vectors++;
        if (mem_addr_o !== base + 32'(4 * fetchIdx)) begin
          miscompares++;
          $display("[TB] FAIL %s mem_addr cycle %0d: got %h want %h", name, c, mem_addr_o,
                   base + 32'(4 * fetchIdx));
        end
        if (waitCnt == waitCycles) begin
          mem_ack_i  = 1'b1;
          mem_data_i = (fetchIdx < 256) ? memWords[fetchIdx] : 32'd0;
          fetchIdx++;
          waitCnt = 0;
        end else begin
          mem_ack_i  = 1'b0;
          mem_data_i = $urandom;
          waitCnt++;
        end
      end else begin
        mem_ack_i  = 1'($urandom_range(0, 1));
        mem_data_i = $urandom;
      end
    end
    mem_ack_i = 1'b0;
    start_i   = 1'b0;
    vectors++;
    if (fetchIdx != len || (len == 0 && sawRd)) begin
      miscompares++;
      $display("[TB] FAIL %s fetch count: got %0d want %0d", name, fetchIdx, len);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    start_i = 1'b1;
    mem_ack_i = 1'b1;
    mem_data_i = 32'hFFFFFFFF;
    base_addr_i = 32'h100;
    len_i = 8'd3;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    vectors++;
    if ({mem_rd_o, busy_o, done_o} !== 3'b000 || mem_addr_o !== 32'd0 ||
        max_val_o !== 32'd0 || max_idx_o !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_values: got rd=%b busy=%b done=%b addr=%h val=%h idx=%h want all 0",
               mem_rd_o, busy_o, done_o, mem_addr_o, max_val_o, max_idx_o);
    end
    reset_i = 1'b0;
    start_i = 1'b0;
    mem_ack_i = 1'b0;
  endtask

  task automatic test_example();
    memWords[0] = 32'd5; memWords[1] = 32'd9; memWords[2] = 32'd3; memWords[3] = 32'd9;
    runOp(32'h100, 4, 0, 1'b0, "example");
    vectors++;
    if (max_val_o !== 32'd9 || max_idx_o !== 32'd1) begin
      miscompares++;
      $display("[TB] FAIL example_const: got %0d@%0d want 9@1", max_val_o, max_idx_o);
    end
  endtask

  task automatic test_sign();
    logic [31:0] wantV;
    logic [31:0] wantI;
    memWords[0] = 32'hFFFFFFFF; memWords[1] = 32'd2;
`ifdef ARGMAX_SIGNED_EN
    wantV = 32'd2; wantI = 32'd1;
`else
    wantV = 32'hFFFFFFFF; wantI = 32'd0;
`endif
    runOp(32'h40, 2, 1, 1'b0, "sign");
    repeat (3) @(negedge clk_i);
    vectors++;
    if (max_val_o !== wantV || max_idx_o !== wantI) begin
      miscompares++;
      $display("[TB] FAIL sign_hold: got %h@%0d want %h@%0d", max_val_o, max_idx_o, wantV, wantI);
    end
  endtask

  task automatic test_len_zero();
    runOp(32'h300, 0, 0, 1'b0, "len_zero");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) memWords[i] = $urandom;
    runOp(32'h500, 3, 2, 1'b1, "wait_and_poke");
  endtask

  task automatic test_reset_mid();
    int k = 0;
    for (int i = 0; i < 5; i++) memWords[i] = $urandom_range(1, 1000);
    @(negedge clk_i);
    start_i = 1'b1;
    base_addr_i = 32'h200;
    len_i = 8'd5;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (mem_rd_o === 1'b1) begin
        mem_ack_i = 1'b1;
        mem_data_i = memWords[k];
        k++;
      end else begin
        mem_ack_i = 1'b0;
      end
    end
    vectors++;
    if (busy_o !== 1'b1 || mem_rd_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_precmp: got busy=%b rd=%b want 1 0", busy_o, mem_rd_o);
    end
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    vectors++;
    if ({mem_rd_o, busy_o, done_o} !== 3'b000 || max_val_o !== 32'd0 || max_idx_o !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_clear: got rd=%b busy=%b done=%b val=%h idx=%h want all 0",
               mem_rd_o, busy_o, done_o, max_val_o, max_idx_o);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      vectors++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_mid_idle: got done=%b busy=%b want 0 0", done_o, busy_o);
      end
    end
    runOp(32'h200, 5, 0, 1'b0, "after_reset");
  endtask

  task automatic test_len_max();
    for (int i = 0; i < 256; i++) memWords[i] = 32'd7;
    runOp(32'h1000, 255, 0, 1'b0, "len_max");
  endtask

  task automatic test_random();
    int len;
    for (int r = 0; r < 12; r++) begin
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++)
        memWords[i] = (r % 2 == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      runOp((r == 5) ? 32'hFFFFFFF8 : ($urandom & 32'hFFFFFFFC), len,
            $urandom_range(0, 3), 1'b0, "random");
    end
  endtask

  initial begin
    reset_i = 1'b0;
    start_i = 1'b0;
    base_addr_i = 32'd0;
    len_i = 8'd0;
    mem_ack_i = 1'b0;
    mem_data_i = 32'd0;
    test_reset();
    test_example();
    test_sign();
    test_len_zero();
    test_back_to_back();
    test_reset_mid();
    test_len_max();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
